pc_predict_unit: RTL

Parametrised fetch-PC generator that replaces the purely combinational next-PC logic with a registered PC, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and misprediction recovery driven from the EX stage. It sits between the instruction fetch stage, which consumes `if_pc` and the prediction, and EX, which resolves B and BR against the condition codes and flags. It also handles stall, halt, flush priority and branch performance counters.

---
 rtl/pc_pkg.sv | 68 ++++++
 rtl/pc_btb.sv | 91 +++++++++
 rtl/pc_predict_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: opcodes, condition codes, flag positions and BTB counter constants
// shared by the fetch-PC prediction unit and its branch target buffer.
package pc_pkg;

    // Opcodes the unit cares about.
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Bit positions inside the {Z,V,N} flag vector.
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    // 2-bit saturating counter encodings.
    localparam logic [1:0] CTR_MIN   = 2'b00;
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;

    // Branch performance counters saturate here.
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        CondNe     = 3'b000,
        CondEq     = 3'b001,
        CondGt     = 3'b010,
        CondLt     = 3'b011,
        CondGe     = 3'b100,
        CondLe     = 3'b101,
        CondOvf    = 3'b110,
        CondAlways = 3'b111
    } cond_t;

    // Evaluates condition code against the {Z,V,N} flags.
    function automatic logic cond_met(input cond_t cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic met;
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        case (cond)
            CondNe:     met = ~z;
            CondEq:     met = z;
            CondGt:     met = ~z & ~n;
            CondLt:     met = n;
            CondGe:     met = z | (~z & ~n);
            CondLe:     met = z | n;
            CondOvf:    met = v;
            CondAlways: met = 1'b1;
            default:    met = 1'b0;
        endcase
        return met;
    endfunction

    // True for the opcodes resolved in EX as branches.
    function automatic logic is_branch_op(input logic [3:0] opcode);
        return (opcode == OP_B) || (opcode == OP_BR);
    endfunction

    // True for the halt opcode; decoded in IF before it reaches this unit.
    function automatic logic is_halt_op(input logic [3:0] opcode);
        return opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with 2-bit saturating counters.
// One asynchronous read port for the fetch PC, one synchronous update port
// driven by branch resolution. Writes land at the clock edge with no bypass.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BTB_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch-side lookup
    input  logic [ADDR_W-1:0] i_rd_pc,
    output logic              o_rd_taken,
    output logic [ADDR_W-1:0] o_rd_target,
    // Resolution-side update
    input  logic              i_upd_en,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic [ADDR_W-1:0] i_upd_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 1;

    logic              r_valid  [BTB_DEPTH];
    logic [TAG_W-1:0]  r_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0] r_target [BTB_DEPTH];
    logic [1:0]        r_ctr    [BTB_DEPTH];

    logic [IDX_W-1:0]  w_rd_idx;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_rd_hit;

    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;
    logic              w_upd_hit;
    logic [1:0]        w_ctr_cur;
    logic [1:0]        w_ctr_inc;
    logic [1:0]        w_ctr_dec;

    // Instructions are halfword aligned, so PC bit 0 never selects an entry.
    logic              w_unused_pc_lsb;
    assign w_unused_pc_lsb = i_rd_pc[0] ^ i_upd_pc[0];

    assign w_rd_idx  = i_rd_pc[IDX_W:1];
    assign w_rd_tag  = i_rd_pc[ADDR_W-1:IDX_W+1];
    assign w_rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);

    assign o_rd_taken  = w_rd_hit & r_ctr[w_rd_idx][1];
    assign o_rd_target = o_rd_taken ? r_target[w_rd_idx] : '0;

    assign w_upd_idx = i_upd_pc[IDX_W:1];
    assign w_upd_tag = i_upd_pc[ADDR_W-1:IDX_W+1];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_ctr_cur = r_ctr[w_upd_idx];

    // Saturating counter steps for the entry being updated.
    always_comb begin
        w_ctr_inc = (w_ctr_cur == CTR_MAX) ? CTR_MAX : w_ctr_cur + 2'd1;
        w_ctr_dec = (w_ctr_cur == CTR_MIN) ? CTR_MIN : w_ctr_cur - 2'd1;
    end

    // Entry storage: clear on reset, train or allocate on resolved branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_RESET;
            end
        end else if (i_upd_en) begin
            if (i_upd_taken) begin
                if (w_upd_hit) begin
                    r_target[w_upd_idx] <= i_upd_target;
                    r_ctr[w_upd_idx]    <= w_ctr_inc;
                end else begin
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= i_upd_target;
                    r_ctr[w_upd_idx]    <= CTR_ALLOC;
                end
            end else if (w_upd_hit) begin
                // Not-taken misses leave the table alone.
                r_ctr[w_upd_idx] <= w_ctr_dec;
            end
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: registered fetch PC with BTB prediction, EX-stage
// misprediction recovery, stall/halt handling and branch statistics.
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       IMM_W     = 9,
    parameter int unsigned       BTB_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch side
    input  logic              stall_if,
    input  logic              halt_if,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_pred_taken,
    output logic [ADDR_W-1:0] if_pred_target,
    // Execute side
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [2:0]        ex_cond,
    input  logic [2:0]        ex_flags,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [IMM_W-1:0]  ex_imm,
    input  logic [ADDR_W-1:0] ex_reg,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    // Control and statistics
    output logic              flush,
    output logic              halted,
    output logic [15:0]       br_count,
    output logic [15:0]       mis_count
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic [15:0]       r_br_count;
    logic [15:0]       r_mis_count;

    logic              w_ex_br;
    logic              w_taken;
    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_b_target;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_flush;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_halted_next;
    logic              w_pred_taken;
    logic [ADDR_W-1:0] w_pred_target;

    pc_btb #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_pc      (r_pc),
        .o_rd_taken   (w_pred_taken),
        .o_rd_target  (w_pred_target),
        .i_upd_en     (w_ex_br),
        .i_upd_taken  (w_taken),
        .i_upd_pc     (ex_pc),
        .i_upd_target (w_target)
    );

    // Branch resolution: direction, actual target and misprediction detect.
    always_comb begin
        w_ex_br       = ex_valid & is_branch_op(ex_opcode);
        w_taken       = cond_met(cond_t'(ex_cond), ex_flags);
        w_imm_ext     = {{(ADDR_W - IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
        // Immediate counts instruction words; all sums wrap modulo 2^ADDR_W.
        w_b_target    = ex_pc + PC_STEP + (w_imm_ext << 1);
        w_target      = (ex_opcode == OP_BR) ? ex_reg : w_b_target;
        w_seq_pc      = ex_pc + PC_STEP;
        w_redirect_pc = w_taken ? w_target : w_seq_pc;
        w_flush       = w_ex_br &
                        ((w_taken != ex_pred_taken) |
                         (w_taken & (w_target != ex_pred_target)));
    end

    // Next-PC selection; flush outranks halt and stall.
    always_comb begin
        w_pc_next     = r_pc;
        w_halted_next = r_halted;
        if (w_flush) begin
            w_pc_next     = w_redirect_pc;
            w_halted_next = 1'b0;
        end else if (r_halted) begin
            w_pc_next = r_pc;
        end else if (halt_if && !stall_if) begin
            w_halted_next = 1'b1;
        end else if (stall_if) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = w_pred_target;
        end else begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    // PC and halt flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_halted <= w_halted_next;
        end
    end

    // Saturating branch and misprediction counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else begin
            if (w_ex_br && (r_br_count != CNT_MAX)) begin
                r_br_count <= r_br_count + 16'd1;
            end
            if (w_flush && (r_mis_count != CNT_MAX)) begin
                r_mis_count <= r_mis_count + 16'd1;
            end
        end
    end

    assign if_pc          = r_pc;
    assign if_pred_taken  = w_pred_taken;
    assign if_pred_target = w_pred_target;
    assign flush          = w_flush;
    assign halted         = r_halted;
    assign br_count       = r_br_count;
    assign mis_count      = r_mis_count;

endmodule
